wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges alu/lsu/mul writebacks onto two registered register-file write ports
// with round-robin arbitration, same-address suppression and a pending-register mask.
`ifndef GRLEN
`define GRLEN 32
`endif
module wb_arbiter (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic              lsu_valid,
    input  logic              mul_valid,
    output logic              alu_ready,
    output logic              lsu_ready,
    output logic              mul_ready,
    input  logic [4:0]        alu_addr,
    input  logic [4:0]        lsu_addr,
    input  logic [4:0]        mul_addr,
    input  logic [`GRLEN-1:0] alu_data,
    input  logic [`GRLEN-1:0] lsu_data,
    input  logic [`GRLEN-1:0] mul_data,
    output logic              wen1,
    output logic [4:0]        waddr1,
    output logic [`GRLEN-1:0] wdata1,
    output logic              wen2,
    output logic [4:0]        waddr2,
    output logic [`GRLEN-1:0] wdata2,
    output logic [31:0]       pending_mask
);
    logic [2:0]        v, rdy, bv, gnt, s;
    logic [4:0]        a [3];
    logic [`GRLEN-1:0] d [3];
    logic [4:0]        ba [3];
    logic [`GRLEN-1:0] bd [3];
    logic [1:0]        rr_ptr, g1, g2, last, n;

    assign v    = {mul_valid, lsu_valid, alu_valid};
    assign a[0] = alu_addr;
    assign a[1] = lsu_addr;
    assign a[2] = mul_addr;
    assign d[0] = alu_data;
    assign d[1] = lsu_data;
    assign d[2] = mul_data;
    assign rdy  = ~bv | gnt;
    assign {mul_ready, lsu_ready, alu_ready} = rdy;

    // r0 entries retire for free; others compete for two ports in rr order
    always_comb begin
        gnt = '0;
        n = '0;
        g1 = '0;
        g2 = '0;
        last = rr_ptr;
        s = '0;
        for (int i = 0; i < 3; i++) begin
            if (bv[i] && ba[i] == 5'd0) gnt[i] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            s = {1'b0, rr_ptr} + 3'(i);
            s = (s >= 3'd3) ? s - 3'd3 : s;
            if (bv[s[1:0]] && ba[s[1:0]] != 5'd0 && n != 2'd2 && !(n == 2'd1 && ba[s[1:0]] == ba[g1])) begin
                gnt[s[1:0]] = 1'b1;
                g1 = (n == 2'd0) ? s[1:0] : g1;
                g2 = (n == 2'd1) ? s[1:0] : g2;
                last = s[1:0];
                n = n + 2'd1;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < 3; i++) begin
            if (bv[i]) pending_mask[ba[i]] = 1'b1;
        end
        if (wen1) pending_mask[waddr1] = 1'b1;
        if (wen2) pending_mask[waddr2] = 1'b1;
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bv <= '0;
            rr_ptr <= '0;
            wen1 <= 1'b0;
            wen2 <= 1'b0;
            waddr1 <= '0;
            waddr2 <= '0;
            wdata1 <= '0;
            wdata2 <= '0;
            for (int i = 0; i < 3; i++) begin
                ba[i] <= '0;
                bd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (v[i] && rdy[i]) begin
                    bv[i] <= 1'b1;
                    ba[i] <= a[i];
                    bd[i] <= d[i];
                end else if (gnt[i]) begin
                    bv[i] <= 1'b0;
                end
            end
            wen1 <= n != 2'd0;
            wen2 <= n == 2'd2;
            if (n != 2'd0) begin
                waddr1 <= ba[g1];
                wdata1 <= bd[g1];
                rr_ptr <= (last == 2'd2) ? 2'd0 : last + 2'd1;
            end
            if (n == 2'd2) begin
                waddr2 <= ba[g2];
                wdata2 <= bd[g2];
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, fairness run and random traffic checked
// against a queue-based reference model of the writeback arbiter.
module tb_wb_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        alu_valid, lsu_valid, mul_valid;
    logic        alu_ready, lsu_ready, mul_ready;
    logic [4:0]  alu_addr, lsu_addr, mul_addr;
    logic [31:0] alu_data, lsu_data, mul_data;
    logic        wen1, wen2;
    logic [4:0]  waddr1, waddr2;
    logic [31:0] wdata1, wdata2, pending_mask;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .lsu_valid(lsu_valid), .mul_valid(mul_valid),
        .alu_ready(alu_ready), .lsu_ready(lsu_ready), .mul_ready(mul_ready),
        .alu_addr(alu_addr), .lsu_addr(lsu_addr), .mul_addr(mul_addr),
        .alu_data(alu_data), .lsu_data(lsu_data), .mul_data(mul_data),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .wen2(wen2), .waddr2(waddr2), .wdata2(wdata2),
        .pending_mask(pending_mask)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: one slot per requester, list of port grants this cycle
    bit          mv [3];
    logic [4:0]  ma [3];
    logic [31:0] md [3];
    int          rr;
    bit          mw1, mw2;
    logic [4:0]  mwa1, mwa2;
    logic [31:0] mwd1, mwd2;
    bit          mg [3];
    int          gl [$];
    logic [2:0]  iv;
    logic [4:0]  ia [3];
    logic [31:0] id [3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            mv[k] = 0;
            ma[k] = 0;
            md[k] = 0;
        end
        rr = 0;
        mw1 = 0;
        mw2 = 0;
        mwa1 = 0;
        mwa2 = 0;
        mwd1 = 0;
        mwd2 = 0;
    endfunction

    function automatic void arb();
        gl.delete();
        for (int k = 0; k < 3; k++) mg[k] = mv[k] && ma[k] == 0;
        for (int j = 0; j < 3; j++) begin
            int k;
            k = (rr + j) % 3;
            if (mv[k] && ma[k] != 0 && gl.size() < 2 && !(gl.size() == 1 && ma[gl[0]] == ma[k])) begin
                gl.push_back(k);
                mg[k] = 1;
            end
        end
    endfunction

    function automatic logic [31:0] mpend();
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < 3; k++) if (mv[k] && ma[k] != 0) p |= 32'd1 << ma[k];
        if (mw1) p |= 32'd1 << mwa1;
        if (mw2) p |= 32'd1 << mwa2;
        return p;
    endfunction

    task automatic drive(input bit r, input logic [2:0] vv, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2);
        @(negedge clk);
        rst = r;
        {mul_valid, lsu_valid, alu_valid} = vv;
        alu_addr = a0; lsu_addr = a1; mul_addr = a2;
        alu_data = d0; lsu_data = d1; mul_data = d2;
        iv = vv;
        ia[0] = a0; ia[1] = a1; ia[2] = a2;
        id[0] = d0; id[1] = d1; id[2] = d2;
        #1;
        arb();
        chk("m_alu_ready", alu_ready, !mv[0] || mg[0]);
        chk("m_lsu_ready", lsu_ready, !mv[1] || mg[1]);
        chk("m_mul_ready", mul_ready, !mv[2] || mg[2]);
        chk("m_wen1", wen1, mw1);
        chk("m_wen2", wen2, mw2);
        chk("m_waddr1", waddr1, mwa1);
        chk("m_waddr2", waddr2, mwa2);
        chk("m_wdata1", wdata1, mwd1);
        chk("m_wdata2", wdata2, mwd2);
        chk("m_pending", pending_mask, mpend());
    endtask

    task automatic tick();
        bit r [3];
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) r[k] = !mv[k] || mg[k];
            mw1 = gl.size() > 0;
            mw2 = gl.size() > 1;
            if (mw1) begin
                mwa1 = ma[gl[0]];
                mwd1 = md[gl[0]];
                rr = (gl[gl.size()-1] + 1) % 3;
            end
            if (mw2) begin
                mwa2 = ma[gl[1]];
                mwd2 = md[gl[1]];
            end
            for (int k = 0; k < 3; k++) begin
                if (iv[k] && r[k]) begin
                    mv[k] = 1;
                    ma[k] = ia[k];
                    md[k] = id[k];
                end else if (mg[k]) begin
                    mv[k] = 0;
                end
            end
        end
    endtask

    typedef struct {
        bit          r;
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        bit          w1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        bit          w2;
        logic [2:0]  rdy;
        logic [31:0] pm;
    } vec_t;

    vec_t vt [22];
    int   cnt [32];
    int   lastc [32];
    int   maxgap;

    initial begin
        vt[0]  = '{0, 3'b001, 5, 0, 0, 'h11, 0, 0,       0, 0, 0,     0, 3'b111, 0};
        vt[1]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b111, 'h20};
        vt[2]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          1, 5, 'h11,  0, 3'b111, 'h20};
        vt[3]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b111, 0};
        vt[4]  = '{1, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b111, 0};
        vt[5]  = '{0, 3'b111, 1, 2, 3, 'hA1, 'hB2, 'hC3, 0, 0, 0,     0, 3'b111, 0};
        vt[6]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b011, 'hE};
        vt[7]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          1, 1, 'hA1,  1, 3'b111, 'hE};
        vt[8]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          1, 3, 'hC3,  0, 3'b111, 'h8};
        vt[9]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b111, 0};
        vt[10] = '{0, 3'b011, 7, 7, 0, 'h70, 'h71, 0,    0, 0, 0,     0, 3'b111, 0};
        vt[11] = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b101, 'h80};
        vt[12] = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          1, 7, 'h70,  0, 3'b111, 'h80};
        vt[13] = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          1, 7, 'h71,  0, 3'b111, 'h80};
        vt[14] = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b111, 0};
        vt[15] = '{0, 3'b010, 0, 0, 0, 0, 'hFFFF, 0,     0, 0, 0,     0, 3'b111, 0};
        vt[16] = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b111, 0};
        vt[17] = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b111, 0};
        vt[18] = '{0, 3'b111, 4, 5, 6, 'h40, 'h50, 'h60, 0, 0, 0,     0, 3'b111, 0};
        vt[19] = '{0, 3'b111, 8, 9, 10, 'h80, 'h90, 'hA0, 0, 0, 0,    0, 3'b101, 'h70};
        vt[20] = '{1, 3'b000, 0, 0, 0, 0, 0, 0,          1, 6, 'h60,  1, 3'b110, 'h570};
        vt[21] = '{0, 3'b000, 0, 0, 0, 0, 0, 0,          0, 0, 0,     0, 3'b111, 0};

        rst = 1'b1;
        {mul_valid, lsu_valid, alu_valid} = 3'b000;
        alu_addr = 0; lsu_addr = 0; mul_addr = 0;
        alu_data = 0; lsu_data = 0; mul_data = 0;
        iv = 0;
        model_reset();
        repeat (3) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].r, vt[i].v, vt[i].a0, vt[i].a1, vt[i].a2, vt[i].d0, vt[i].d1, vt[i].d2);
            chk($sformatf("t%0d_wen1", i), wen1, vt[i].w1);
            chk($sformatf("t%0d_wen2", i), wen2, vt[i].w2);
            chk($sformatf("t%0d_ready", i), {mul_ready, lsu_ready, alu_ready}, vt[i].rdy);
            chk($sformatf("t%0d_pending", i), pending_mask, vt[i].pm);
            if (vt[i].w1) begin
                chk($sformatf("t%0d_waddr1", i), waddr1, vt[i].wa1);
                chk($sformatf("t%0d_wdata1", i), wdata1, vt[i].wd1);
            end
            tick();
        end

        // fairness: three distinct destinations held valid continuously
        for (int k = 0; k < 32; k++) begin
            cnt[k] = 0;
            lastc[k] = -1;
        end
        maxgap = 0;
        for (int c = 0; c < 32; c++) begin
            drive(0, 3'b111, 1, 2, 3, c, c + 100, c + 200);
            if (c >= 2) begin
                if (wen1) begin
                    cnt[waddr1]++;
                    if (lastc[waddr1] >= 0 && c - lastc[waddr1] > maxgap) maxgap = c - lastc[waddr1];
                    lastc[waddr1] = c;
                end
                if (wen2) begin
                    cnt[waddr2]++;
                    if (lastc[waddr2] >= 0 && c - lastc[waddr2] > maxgap) maxgap = c - lastc[waddr2];
                    lastc[waddr2] = c;
                end
            end
            tick();
        end
        chk("fair_cnt_r1", cnt[1], 20);
        chk("fair_cnt_r2", cnt[2], 20);
        chk("fair_cnt_r3", cnt[3], 20);
        chk("fair_maxgap_le2", maxgap <= 2, 1);
        repeat (4) begin
            drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
            tick();
        end

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 63) == 0, 3'($urandom), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
